// File: rtl/div_pkg.sv
// ============================================================================
// Module : div_pkg
// Shared state encodings and default width for the restoring divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_restoring_divider.sv
// ============================================================================
// Module : seq_restoring_divider
// Multi-cycle unsigned restoring divider driving an external add/sub stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         dbz,
  output logic [N-1:0] add_x,
  output logic [N-1:0] add_y,
  output logic         add_sel,
  input  logic [N-1:0] add_s,
  input  logic         add_c
);

  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

  state_t         r_state;
  state_t         w_next_state;
  logic [N-1:0]   r_rem;
  logic [N-1:0]   r_quo;
  logic [N-1:0]   r_div;
  logic [CNT_W-1:0] r_cnt;
  logic           r_dbz;
  logic           w_ge;
  logic           w_last;
  logic [N-1:0]   w_rem_step;
  logic [N-1:0]   w_quo_step;

  assign add_x   = {r_rem[N-2:0], r_quo[N-1]};
  assign add_y   = r_div;
  assign add_sel = 1'b1;

  // A set msb means the shifted value is at least 2^N, so it always exceeds D.
  assign w_ge       = r_rem[N-1] | add_c;
  assign w_rem_step = w_ge ? add_s : add_x;
  assign w_quo_step = {r_quo[N-2:0], w_ge};
  assign w_last     = (r_cnt == C_LAST);

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next_state = BUSY;
      BUSY:    if (w_last) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_dbz     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_div <= divisor;
            r_cnt <= '0;
            r_dbz <= (divisor == '0);
          end
        end
        BUSY: begin
          r_rem <= w_rem_step;
          r_quo <= w_quo_step;
          r_cnt <= r_cnt + 1'b1;
          // Published outputs only change when a new result is presented.
          if (w_last) begin
            quotient  <= w_quo_step;
            remainder <= w_rem_step;
            dbz       <= r_dbz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
// Module : tb_seq_restoring_divider
// Scoreboard bench for seq_restoring_divider at N=8 and N=16.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc++;

  // N=8 instance signals
  logic        in_valid8, in_ready8, out_valid8, out_ready8, dbz8;
  logic [7:0]  dividend8, divisor8, quotient8, remainder8;
  logic [7:0]  add_x8, add_y8, add_s8;
  logic        add_sel8, add_c8;
  // N=16 instance signals
  logic        in_valid16, in_ready16, out_valid16, out_ready16, dbz16;
  logic [15:0] dividend16, divisor16, quotient16, remainder16;
  logic [15:0] add_x16, add_y16, add_s16;
  logic        add_sel16, add_c16;

  // Add/sub stages sitting beside each divider
  assign {add_c8, add_s8} = add_sel8 ? ({1'b0, add_x8} + {1'b0, ~add_y8} + 9'd1)
                                     : ({1'b0, add_x8} + {1'b0, add_y8});
  assign {add_c16, add_s16} = add_sel16 ? ({1'b0, add_x16} + {1'b0, ~add_y16} + 17'd1)
                                        : ({1'b0, add_x16} + {1'b0, add_y16});

  seq_restoring_divider #(.N(8)) u_div8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .dividend(dividend8), .divisor(divisor8), .out_valid(out_valid8), .out_ready(out_ready8),
    .quotient(quotient8), .remainder(remainder8), .dbz(dbz8),
    .add_x(add_x8), .add_y(add_y8), .add_sel(add_sel8), .add_s(add_s8), .add_c(add_c8)
  );

  seq_restoring_divider #(.N(16)) u_div16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .dividend(dividend16), .divisor(divisor16), .out_valid(out_valid16), .out_ready(out_ready16),
    .quotient(quotient16), .remainder(remainder16), .dbz(dbz16),
    .add_x(add_x16), .add_y(add_y16), .add_sel(add_sel16), .add_s(add_s16), .add_c(add_c16)
  );

  typedef struct {
    longint q;
    longint r;
    longint dbz;
    longint t;
  } exp_t;

  exp_t sb8[$];
  exp_t sb16[$];
  int checks = 0;
  int failures = 0;
  int mode8 = 0;
  int mode16 = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=completion", name);
  endtask

  // Reference: plain integer division; divide-by-zero gives all ones / dividend.
  function automatic exp_t model(input longint a, input longint b, input int n, input longint t);
    exp_t e;
    if (b == 0) begin
      e.q = (longint'(1) << n) - 1;
      e.r = a;
      e.dbz = 1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 0;
    end
    e.t = t;
    return e;
  endfunction

  // Consumer-side ready: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    out_ready8 = 1'b0;
    out_ready16 = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (mode8)
        0: out_ready8 = 1'b1;
        1: out_ready8 = 1'($urandom_range(0, 1));
        default: out_ready8 = 1'b0;
      endcase
      case (mode16)
        0: out_ready16 = 1'b1;
        1: out_ready16 = 1'($urandom_range(0, 1));
        default: out_ready16 = 1'b0;
      endcase
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b);
    int w = 0;
    @(negedge clk);
    in_valid8 = 1'b1; dividend8 = a; divisor8 = b;
    while (!in_ready8 && w < 400) begin @(negedge clk); w++; end
    if (!in_ready8) begin
      timeout_fail("u8_accept");
    end else begin
      sb8.push_back(model(longint'(a), longint'(b), 8, cyc));
    end
    @(negedge clk);
    in_valid8 = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b);
    int w = 0;
    @(negedge clk);
    in_valid16 = 1'b1; dividend16 = a; divisor16 = b;
    while (!in_ready16 && w < 400) begin @(negedge clk); w++; end
    if (!in_ready16) begin
      timeout_fail("u16_accept");
    end else begin
      sb16.push_back(model(longint'(a), longint'(b), 16, cyc));
    end
    @(negedge clk);
    in_valid16 = 1'b0;
  endtask

  task automatic wait_done8();
    int w = 0;
    while (sb8.size() != 0 && w < 400) begin @(negedge clk); w++; end
    if (sb8.size() != 0) timeout_fail("u8_result");
  endtask

  task automatic wait_done16();
    int w = 0;
    while (sb16.size() != 0 && w < 400) begin @(negedge clk); w++; end
    if (sb16.size() != 0) timeout_fail("u16_result");
  endtask

  // Monitors: latency on rise, stability under backpressure, values on handshake
  logic pv8 = 1'b0, hold8 = 1'b0, hd8 = 1'b0;
  logic [7:0] hq8 = '0, hr8 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pv8 = 1'b0; hold8 = 1'b0;
    end else begin
      if (out_valid8 && !pv8) begin
        if (sb8.size() == 0) timeout_fail("u8_unexpected_output");
        else check("u8_latency", cyc - sb8[0].t, 9);
      end
      if (hold8) begin
        check("u8_hold_valid", longint'(out_valid8), 1);
        check("u8_hold_quotient", longint'(quotient8), longint'(hq8));
        check("u8_hold_remainder", longint'(remainder8), longint'(hr8));
        check("u8_hold_dbz", longint'(dbz8), longint'(hd8));
      end
      if (out_valid8 && out_ready8 && sb8.size() != 0) begin
        e = sb8.pop_front();
        check("u8_quotient", longint'(quotient8), e.q);
        check("u8_remainder", longint'(remainder8), e.r);
        check("u8_dbz", longint'(dbz8), e.dbz);
      end
      hold8 = out_valid8 && !out_ready8;
      hq8 = quotient8; hr8 = remainder8; hd8 = dbz8;
      pv8 = out_valid8;
    end
  end

  logic pv16 = 1'b0, hold16 = 1'b0, hd16 = 1'b0;
  logic [15:0] hq16 = '0, hr16 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pv16 = 1'b0; hold16 = 1'b0;
    end else begin
      if (out_valid16 && !pv16) begin
        if (sb16.size() == 0) timeout_fail("u16_unexpected_output");
        else check("u16_latency", cyc - sb16[0].t, 17);
      end
      if (hold16) begin
        check("u16_hold_valid", longint'(out_valid16), 1);
        check("u16_hold_quotient", longint'(quotient16), longint'(hq16));
        check("u16_hold_remainder", longint'(remainder16), longint'(hr16));
        check("u16_hold_dbz", longint'(dbz16), longint'(hd16));
      end
      if (out_valid16 && out_ready16 && sb16.size() != 0) begin
        e = sb16.pop_front();
        check("u16_quotient", longint'(quotient16), e.q);
        check("u16_remainder", longint'(remainder16), e.r);
        check("u16_dbz", longint'(dbz16), e.dbz);
      end
      hold16 = out_valid16 && !out_ready16;
      hq16 = quotient16; hr16 = remainder16; hd16 = dbz16;
      pv16 = out_valid16;
    end
  end

  function automatic logic [15:0] rand_divisor(input logic [15:0] mask);
    case ($urandom_range(0, 7))
      0: return 16'd0;
      1: return 16'd1;
      2: return 16'($urandom_range(1, 15));
      default: return 16'($urandom) & mask;
    endcase
  endfunction

  initial begin
    in_valid8 = 1'b0; dividend8 = '0; divisor8 = '0;
    in_valid16 = 1'b0; dividend16 = '0; divisor16 = '0;

    #12;
    check("reset_in_ready", longint'(in_ready8), 1);
    check("reset_out_valid", longint'(out_valid8), 0);
    check("reset_quotient", longint'(quotient8), 0);
    check("reset_remainder", longint'(remainder8), 0);
    check("reset_dbz", longint'(dbz8), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases
    send8(8'd100, 8'd7);   wait_done8();
    send8(8'd255, 8'd200); wait_done8();
    send8(8'd255, 8'd1);   wait_done8();
    send8(8'd3, 8'd250);   wait_done8();
    send8(8'd200, 8'd0);   wait_done8();

    // Backpressure in DONE with ignored input pulses
    mode8 = 2;
    send8(8'd100, 8'd7);
    begin
      int w = 0;
      while (!out_valid8 && w < 100) begin @(negedge clk); w++; end
      if (!out_valid8) timeout_fail("u8_bp_valid");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid8 = 1'b1; dividend8 = 8'd1; divisor8 = 8'd1;
      check("bp_in_ready", longint'(in_ready8), 0);
    end
    @(negedge clk);
    in_valid8 = 1'b0;
    mode8 = 0;
    wait_done8();
    send8(8'd77, 8'd5); wait_done8();

    // Reset in the middle of a division
    @(negedge clk);
    in_valid8 = 1'b1; dividend8 = 8'd100; divisor8 = 8'd7;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", longint'(in_ready8), 1);
    check("midreset_out_valid", longint'(out_valid8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abandoned_out_valid", longint'(out_valid8), 0);
    send8(8'd100, 8'd7); wait_done8();

    // Random sweep on both widths with random backpressure
    mode8 = 1;
    mode16 = 1;
    fork
      for (int i = 0; i < 2000; i++) begin
        send8(8'($urandom), rand_divisor(16'h00ff)[7:0]);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      for (int j = 0; j < 1000; j++) begin
        send16(16'($urandom), rand_divisor(16'hffff));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    join
    wait_done8();
    wait_done16();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
